// File: rtl/ifu_prefetch_ysyx_24100029.sv
// rtl/ifu_prefetch_ysyx_24100029.sv - instruction fetch front end with prefetch FIFO and redirect flush
//
// Issues one word fetch at a time to instruction memory (req/gnt/rvalid),
// buffers returned {pc, inst} pairs in a QDEPTH-entry FIFO and presents the
// head to decode over valid/ready. A redirect flushes the FIFO and restarts
// fetch at the new target; a response already owed by memory is swallowed.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   redirect_valid/redirect_pc  flush and restart fetch at redirect_pc & ~3
//   imem_req/imem_addr          registered fetch request and word address
//   imem_gnt                    request accepted this cycle
//   imem_rvalid/imem_rdata      in-order response for the granted request
//   out_valid/out_ready         decode handshake on the FIFO head
//   out_pc/out_inst             registered head entry, zero when empty
//   fetch_pc                    next address to be requested
module ifu_prefetch_ysyx_24100029 #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] fetch_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t        state;
  logic [31:0]   issued_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];

  logic          pop;
  logic          push;
  logic          space;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr_next;
  logic [31:0]   redirect_tgt;
  logic [31:0]   head_pc_next;
  logic [31:0]   head_inst_next;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // A redirect discards both the same-cycle pop and any same-cycle response.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = (state == S_WAIT) && imem_rvalid && !redirect_valid;

  assign count_next  = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));
  assign rd_ptr_next = rd_ptr + PW'(pop);

  // Occupancy after this cycle's push/pop; covers both the IDLE wake-up
  // check and the WAIT "room for another fetch" check.
  assign space = (count_next < DEPTH_C);

  // Head for the registered output: if the FIFO drains to nothing except
  // the incoming push, the push itself becomes the head (it is not yet in
  // the storage array this cycle).
  always_comb begin
    head_pc_next   = '0;
    head_inst_next = '0;
    if (count_next != '0) begin
      if (count == CW'(pop)) begin
        head_pc_next   = issued_pc;
        head_inst_next = imem_rdata;
      end else begin
        head_pc_next   = q_pc[rd_ptr_next];
        head_inst_next = q_inst[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= issued_pc;
      q_inst[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      issued_pc <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
    end else begin
      count     <= count_next;
      rd_ptr    <= redirect_valid ? '0 : rd_ptr_next;
      wr_ptr    <= redirect_valid ? '0 : (wr_ptr + PW'(push));
      out_valid <= (count_next != '0);
      out_pc    <= head_pc_next;
      out_inst  <= head_inst_next;

      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        // A response is still owed if a request was granted and not yet
        // answered, including one granted in this very cycle.
        if (((state == S_WAIT) && !imem_rvalid) ||
            ((state == S_REQ)  && imem_gnt)     ||
            ((state == S_DROP) && !imem_rvalid)) begin
          state    <= S_DROP;
          imem_req <= 1'b0;
        end else begin
          state     <= S_REQ;
          imem_req  <= 1'b1;
          imem_addr <= redirect_tgt;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (space) begin
              state     <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
            end
          end
          S_REQ: begin
            if (imem_gnt) begin
              state     <= S_WAIT;
              imem_req  <= 1'b0;
              issued_pc <= fetch_pc;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              fetch_pc <= fetch_pc + 32'd4;
              if (space) begin
                state     <= S_REQ;
                imem_req  <= 1'b1;
                imem_addr <= fetch_pc + 32'd4;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_DROP: begin
            if (imem_rvalid) begin
              state     <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
